// File: rtl/cpu_pkg.sv
// Shared CPU defaults and the opcode-independent hazard-source record used by
// the issue-stage scoreboard.
package cpu_pkg;

    localparam int NUM_REGS_DEF     = 32;
    localparam int REG_W            = 5;
    localparam int MAX_INFLIGHT_DEF = 3;
    localparam int BRANCH_STALL_DEF = 1;

    typedef struct packed {
        logic [REG_W-1:0] rs1;
        logic             rs1_used;
        logic [REG_W-1:0] rs2;
        logic             rs2_used;
        logic [REG_W-1:0] rd;
        logic             wr;
        logic             is_branch;
    } hazard_src_t;

endpackage

// File: rtl/pending_counter.sv
// Saturating up/down counter of outstanding writes to one architectural
// register; flags a decrement attempted at zero.
module pending_counter #(
    parameter int W   = 2,
    parameter int MAX = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         underflow
);

    assign underflow = dec && !inc && (count == '0);

    // Simultaneous inc and dec cancel; both ends clamp instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !dec && (count != W'(MAX))) begin
            count <= count + 1'b1;
        end else if (dec && !inc && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order issue scoreboard: per-register pending-write counters, in-flight
// occupancy, branch-pending tracking and a sticky protocol-error flag.
module hazard_scoreboard
    import cpu_pkg::*;
#(
    parameter int NUM_REGS     = cpu_pkg::NUM_REGS_DEF,
    parameter int REG_W        = cpu_pkg::REG_W,
    parameter int MAX_INFLIGHT = cpu_pkg::MAX_INFLIGHT_DEF,
    parameter int BRANCH_STALL = cpu_pkg::BRANCH_STALL_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              issue_valid,
    input  logic [REG_W-1:0]                  issue_rs1,
    input  logic [REG_W-1:0]                  issue_rs2,
    input  logic                              issue_rs1_used,
    input  logic                              issue_rs2_used,
    input  logic [REG_W-1:0]                  issue_rd,
    input  logic                              issue_wr,
    input  logic                              issue_is_branch,
    input  logic                              retire_valid,
    input  logic [REG_W-1:0]                  retire_rd,
    input  logic                              retire_wr,
    input  logic                              branch_resolve,
    output logic                              stall,
    output logic                              issue_fire,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
    output logic                              err
);

    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    typedef logic [IW-1:0] count_t;

    hazard_src_t          src;
    count_t               pend [NUM_REGS];
    logic [NUM_REGS-1:0]  under;
    logic [2**REG_W-1:0]  busy;
    count_t               inflight_q;
    logic                 branch_pending;
    logic                 err_q;
    logic                 inflight_under;
    logic                 resolve_err;

    assign src = '{rs1: issue_rs1, rs1_used: issue_rs1_used,
                   rs2: issue_rs2, rs2_used: issue_rs2_used,
                   rd: issue_rd, wr: issue_wr, is_branch: issue_is_branch};

    assign pend[0]  = '0;
    assign under[0] = 1'b0;

    genvar g;
    for (g = 1; g < NUM_REGS; g++) begin : g_pend
        pending_counter #(
            .W   (IW),
            .MAX (MAX_INFLIGHT)
        ) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (issue_fire && src.wr && (src.rd == REG_W'(g))),
            .dec       (retire_valid && retire_wr && (retire_rd == REG_W'(g))),
            .count     (pend[g]),
            .underflow (under[g])
        );
    end

    // Addresses beyond NUM_REGS (and r0) never report a pending write.
    for (g = 0; g < 2**REG_W; g++) begin : g_busy
        if (g > 0 && g < NUM_REGS) begin : g_live
            assign busy[g] = (pend[g] != '0);
        end else begin : g_zero
            assign busy[g] = 1'b0;
        end
    end

    always_comb begin
        stall = 1'b0;
        if (issue_valid) begin
            stall = (src.rs1_used && busy[src.rs1])
                 || (src.rs2_used && busy[src.rs2])
                 || ((BRANCH_STALL != 0) && branch_pending)
                 || (inflight_q == IW'(MAX_INFLIGHT));
        end
    end

    assign issue_fire     = issue_valid && !stall;
    assign inflight_under = retire_valid && !issue_fire && (inflight_q == '0);
    assign resolve_err    = branch_resolve && !branch_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q     <= '0;
            branch_pending <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            if (issue_fire && !retire_valid && (inflight_q != IW'(MAX_INFLIGHT))) begin
                inflight_q <= inflight_q + 1'b1;
            end else if (retire_valid && !issue_fire && (inflight_q != '0)) begin
                inflight_q <= inflight_q - 1'b1;
            end

            if (issue_fire && src.is_branch) begin
                branch_pending <= 1'b1;
            end else if (branch_resolve) begin
                branch_pending <= 1'b0;
            end

            if ((|under) || inflight_under || resolve_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign inflight = inflight_q;
    assign err      = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed checks of the hazard scoreboard: RAW, WAW, r0, branch modes,
// occupancy limit, error flag and reset priority.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid;
    logic [4:0] issue_rs1, issue_rs2, issue_rd, retire_rd;
    logic       issue_rs1_used, issue_rs2_used, issue_wr, issue_is_branch;
    logic       retire_valid, retire_wr, branch_resolve;
    logic       stall, issue_fire, err;
    logic [1:0] inflight;
    logic       nb_stall, nb_fire, nb_err;
    logic [1:0] nb_inflight;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
        .issue_rd(issue_rd), .issue_wr(issue_wr), .issue_is_branch(issue_is_branch),
        .retire_valid(retire_valid), .retire_rd(retire_rd), .retire_wr(retire_wr),
        .branch_resolve(branch_resolve), .stall(stall), .issue_fire(issue_fire),
        .inflight(inflight), .err(err)
    );

    hazard_scoreboard #(.BRANCH_STALL(0)) dut_nb (
        .clk(clk), .rst(rst), .issue_valid(issue_valid),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
        .issue_rd(issue_rd), .issue_wr(issue_wr), .issue_is_branch(issue_is_branch),
        .retire_valid(retire_valid), .retire_rd(retire_rd), .retire_wr(retire_wr),
        .branch_resolve(branch_resolve), .stall(nb_stall), .issue_fire(nb_fire),
        .inflight(nb_inflight), .err(nb_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rs1_used = 0;
        issue_rs2_used = 0; issue_rd = 0; issue_wr = 0; issue_is_branch = 0;
        retire_valid = 0; retire_rd = 0; retire_wr = 0; branch_resolve = 0;
    endtask

    task automatic drive_issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                               input logic u2, input logic [4:0] rd, input logic wr,
                               input logic br);
        issue_valid = 1; issue_rs1 = rs1; issue_rs1_used = u1; issue_rs2 = rs2;
        issue_rs2_used = u2; issue_rd = rd; issue_wr = wr; issue_is_branch = br;
    endtask

    task automatic retire(input logic [4:0] rd, input logic wr);
        retire_valid = 1; retire_rd = rd; retire_wr = wr;
    endtask

    initial begin
        rst = 1; idle();
        tick(); tick();
        rst = 0;
        check("rst_inflight", 32'(inflight), 0);
        check("rst_err", 32'(err), 0);
        check("rst_stall_idle", 32'(stall), 0);
        drive_issue(1, 1, 2, 1, 0, 0, 0);
        #1;
        check("post_rst_stall", 32'(stall), 0);
        check("post_rst_fire", 32'(issue_fire), 1);
        issue_valid = 0;

        // RAW on r5
        drive_issue(0, 0, 0, 0, 5, 1, 0);
        tick(); idle();
        check("raw_inflight1", 32'(inflight), 1);
        check("raw_pend5", 32'(dut.pend[5]), 1);
        drive_issue(5, 1, 0, 0, 0, 0, 0);
        #1;
        check("raw_stall", 32'(stall), 1);
        check("raw_fire", 32'(issue_fire), 0);
        tick();
        check("raw_stall_hold", 32'(stall), 1);
        retire(5, 1);
        #1;
        check("raw_no_bypass", 32'(stall), 1);
        tick();
        retire_valid = 0; retire_wr = 0;
        #1;
        check("raw_release", 32'(stall), 0);
        check("raw_release_fire", 32'(issue_fire), 1);
        tick(); idle();
        retire(0, 0);
        tick(); idle();
        check("raw_drain", 32'(inflight), 0);

        // WAW on r7
        drive_issue(0, 0, 0, 0, 7, 1, 0);
        tick(); tick(); idle();
        check("waw_pend2", 32'(dut.pend[7]), 2);
        check("waw_inflight2", 32'(inflight), 2);
        retire(7, 1);
        tick(); idle();
        check("waw_pend1", 32'(dut.pend[7]), 1);
        drive_issue(0, 0, 7, 1, 0, 0, 0);
        #1;
        check("waw_stall", 32'(stall), 1);
        retire(7, 1);
        tick();
        retire_valid = 0; retire_wr = 0;
        #1;
        check("waw_release", 32'(stall), 0);
        issue_valid = 0;

        // r0 never pends
        drive_issue(0, 0, 0, 0, 0, 1, 0);
        tick(); idle();
        check("r0_pend", 32'(dut.pend[0]), 0);
        drive_issue(0, 1, 0, 0, 0, 0, 0);
        #1;
        check("r0_nostall", 32'(stall), 0);
        issue_valid = 0;
        retire(0, 1);
        tick(); idle();
        check("r0_no_err", 32'(err), 0);

        // Branch stall modes
        drive_issue(0, 0, 0, 0, 0, 0, 1);
        tick(); idle();
        drive_issue(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("br_stall", 32'(stall), 1);
        check("br_nb_nostall", 32'(nb_stall), 0);
        branch_resolve = 1;
        #1;
        check("br_no_bypass", 32'(stall), 1);
        issue_valid = 0;
        tick();
        branch_resolve = 0; issue_valid = 1;
        #1;
        check("br_release", 32'(stall), 0);
        issue_valid = 0;
        retire(0, 0);
        tick(); idle();
        check("br_drain", 32'(inflight), 0);

        // Occupancy limit
        drive_issue(0, 0, 0, 0, 0, 0, 0);
        tick(); tick(); tick();
        check("full_inflight3", 32'(inflight), 3);
        check("full_stall", 32'(stall), 1);
        check("full_fire", 32'(issue_fire), 0);
        issue_valid = 0;
        retire(0, 0);
        tick(); idle();
        check("full_retire", 32'(inflight), 2);
        drive_issue(0, 0, 0, 0, 0, 0, 0);
        retire(0, 0);
        tick(); idle();
        check("same_cycle_hold", 32'(inflight), 2);
        drive_issue(0, 0, 0, 0, 0, 0, 0);
        tick();
        check("refill_inflight3", 32'(inflight), 3);
        check("fourth_stall", 32'(stall), 1);
        idle();
        retire(0, 0);
        tick(); tick(); tick(); idle();
        check("full_drain", 32'(inflight), 0);

        // Underflow error, sticky
        check("err_clear", 32'(err), 0);
        retire(0, 0);
        tick(); idle();
        check("err_set", 32'(err), 1);
        check("err_no_wrap", 32'(inflight), 0);
        tick(); tick();
        check("err_held", 32'(err), 1);

        // Reset mid-operation wins over same-cycle events
        rst = 1;
        tick();
        rst = 0;
        check("rst_err_clear", 32'(err), 0);
        drive_issue(0, 0, 0, 0, 10, 1, 0);
        tick();
        drive_issue(0, 0, 0, 0, 11, 1, 0);
        tick(); idle();
        check("mid_inflight2", 32'(inflight), 2);
        check("mid_pend11", 32'(dut.pend[11]), 1);
        rst = 1;
        drive_issue(0, 0, 0, 0, 12, 1, 1);
        retire(10, 1);
        branch_resolve = 1;
        tick();
        rst = 0; idle();
        check("mid_rst_inflight", 32'(inflight), 0);
        check("mid_rst_err", 32'(err), 0);
        check("mid_rst_pend10", 32'(dut.pend[10]), 0);
        check("mid_rst_pend11", 32'(dut.pend[11]), 0);
        check("mid_rst_pend12", 32'(dut.pend[12]), 0);
        drive_issue(10, 1, 11, 1, 0, 0, 0);
        #1;
        check("mid_rst_nostall", 32'(stall), 0);
        check("mid_rst_fire", 32'(issue_fire), 1);
        issue_valid = 0;

        // Resolve with no branch pending
        branch_resolve = 1;
        tick(); idle();
        check("resolve_err", 32'(err), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
